// File: rtl/pad_gpio_bank.sv
// GPIO core between the pad ring and on-chip logic: pad synchronisers, output/inout drive,
// sticky rising-edge interrupt flags, MIRROR pass-through and LOOPBACK self-test.
module pad_gpio_bank #(
    parameter int unsigned WIDTH       = 14,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] chip_in,
    input  logic [WIDTH-1:0] io_i,
    output logic [WIDTH-1:0] io_o,
    output logic [WIDTH-1:0] io_oe,
    output logic [WIDTH-1:0] chip_out,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             irq
);

    localparam int unsigned CTRL_W    = 2;
    localparam logic [2:0]  ADDR_OUT   = 3'd0;
    localparam logic [2:0]  ADDR_IOOUT = 3'd1;
    localparam logic [2:0]  ADDR_IOOE  = 3'd2;
    localparam logic [2:0]  ADDR_IN    = 3'd3;
    localparam logic [2:0]  ADDR_IOIN  = 3'd4;
    localparam logic [2:0]  ADDR_EN    = 3'd5;
    localparam logic [2:0]  ADDR_FLAG  = 3'd6;
    localparam logic [2:0]  ADDR_CTRL  = 3'd7;

    logic [WIDTH-1:0]  r_out;
    logic [WIDTH-1:0]  r_io_out;
    logic [WIDTH-1:0]  r_io_oe;
    logic [WIDTH-1:0]  r_edge_en;
    logic [WIDTH-1:0]  r_edge_flag;
    logic [CTRL_W-1:0] r_ctrl;
    logic [WIDTH-1:0]  r_prev;
    logic [WIDTH-1:0]  r_chip_out;
    logic [WIDTH-1:0]  r_io_oe_pad;
    logic [WIDTH-1:0]  r_rdata;
    logic              r_rvalid;
    logic [WIDTH-1:0]  r_sync_in [SYNC_STAGES];
    logic [WIDTH-1:0]  r_sync_io [SYNC_STAGES];

    logic [WIDTH-1:0]  w_sync_in;
    logic [WIDTH-1:0]  w_sync_io;
    logic [WIDTH-1:0]  w_io_src;
    logic [WIDTH-1:0]  w_rise;
    logic [WIDTH-1:0]  w_clr;
    logic [WIDTH-1:0]  w_out_nxt;
    logic [WIDTH-1:0]  w_io_out_nxt;
    logic [WIDTH-1:0]  w_io_oe_nxt;
    logic [WIDTH-1:0]  w_en_nxt;
    logic [WIDTH-1:0]  w_flag_nxt;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic [WIDTH-1:0]  w_rd_data;

    assign w_sync_in = r_sync_in[SYNC_STAGES-1];
    assign w_sync_io = r_sync_io[SYNC_STAGES-1];
    assign w_io_src  = r_ctrl[1] ? r_io_out : io_i;
    assign w_rise    = w_sync_in & ~r_prev;

    // Synchroniser chains; SYNC_STAGES is expected to be 2..4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync_in[i] <= '0;
                r_sync_io[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync_in[0] <= chip_in;
            r_sync_io[0] <= w_io_src;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync_in[i] <= r_sync_in[i-1];
                r_sync_io[i] <= r_sync_io[i-1];
            end
            r_prev <= w_sync_in;
        end
    end

    // Register write decode; a rise coincident with its W1C clear keeps the flag set
    always_comb begin
        w_out_nxt    = r_out;
        w_io_out_nxt = r_io_out;
        w_io_oe_nxt  = r_io_oe;
        w_en_nxt     = r_edge_en;
        w_ctrl_nxt   = r_ctrl;
        w_clr        = '0;
        if (wr_en) begin
            case (addr)
                ADDR_OUT:   w_out_nxt    = wdata;
                ADDR_IOOUT: w_io_out_nxt = wdata;
                ADDR_IOOE:  w_io_oe_nxt  = wdata;
                ADDR_EN:    w_en_nxt     = wdata;
                ADDR_FLAG:  w_clr        = wdata;
                ADDR_CTRL:  w_ctrl_nxt   = wdata[CTRL_W-1:0];
                default:    ;
            endcase
        end
        w_flag_nxt = (r_edge_flag & ~w_clr) | (w_rise & r_edge_en);
    end

    // Readback mux sees pre-write state
    always_comb begin
        w_rd_data = '0;
        case (addr)
            ADDR_OUT:   w_rd_data = r_out;
            ADDR_IOOUT: w_rd_data = r_io_out;
            ADDR_IOOE:  w_rd_data = r_io_oe;
            ADDR_IN:    w_rd_data = w_sync_in;
            ADDR_IOIN:  w_rd_data = w_sync_io;
            ADDR_EN:    w_rd_data = r_edge_en;
            ADDR_FLAG:  w_rd_data = r_edge_flag;
            ADDR_CTRL:  w_rd_data = WIDTH'(r_ctrl);
            default:    w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_io_out    <= '0;
            r_io_oe     <= '0;
            r_edge_en   <= '0;
            r_edge_flag <= '0;
            r_ctrl      <= '0;
            r_chip_out  <= '0;
            r_io_oe_pad <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
        end else begin
            r_out       <= w_out_nxt;
            r_io_out    <= w_io_out_nxt;
            r_io_oe     <= w_io_oe_nxt;
            r_edge_en   <= w_en_nxt;
            r_edge_flag <= w_flag_nxt;
            r_ctrl      <= w_ctrl_nxt;
            // Pad drivers follow the post-write mode so a CTRL write takes effect next cycle
            r_chip_out  <= w_ctrl_nxt[0] ? w_sync_in : w_out_nxt;
            r_io_oe_pad <= w_ctrl_nxt[1] ? '0 : w_io_oe_nxt;
            r_rvalid    <= rd_en;
            if (rd_en) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    assign io_o     = r_io_out;
    assign io_oe    = r_io_oe_pad;
    assign chip_out = r_chip_out;
    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign irq      = |(r_edge_flag & r_edge_en);

endmodule

// File: tb/tb_pad_gpio_bank.sv
// Self-checking bench for pad_gpio_bank: register vector table, directed corner sequences,
// and randomized traffic against a delay-line reference model.
module tb_pad_gpio_bank;

    localparam int unsigned W = 14;
    localparam int unsigned S = 2;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] chip_in;
    logic [W-1:0] io_i;
    logic [W-1:0] io_o;
    logic [W-1:0] io_oe;
    logic [W-1:0] chip_out;
    logic         wr_en;
    logic         rd_en;
    logic [2:0]   addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic         rvalid;
    logic         irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]   a;
        logic [W-1:0] d;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vt [8];

    pad_gpio_bank #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .chip_in  (chip_in),
        .io_i     (io_i),
        .io_o     (io_o),
        .io_oe    (io_oe),
        .chip_out (chip_out),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        chip_in = '0;
        io_i    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (S + 2) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [W-1:0] exp);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({name, " rvalid"}, W'(rvalid), W'(1'b1));
        chk(name, rdata, exp);
    endtask

    // Reference model: pads modelled as delay lines of captured samples, registers as plain state
    task automatic run_random(input int cycles);
        logic [W-1:0] qin[$];
        logic [W-1:0] qio[$];
        logic [W-1:0] m_out, m_io_out, m_io_oe, m_en, m_flag, m_rdata;
        logic [1:0]   m_ctrl;
        logic         m_rvalid;
        logic [W-1:0] s_in, p_in, s_io, rise, clr, rv, io_src;
        logic [W-1:0] e_chip_out, e_io_oe;
        logic [1:0]   op;
        logic [2:0]   a;
        logic [W-1:0] d;

        do_reset();
        m_out = '0; m_io_out = '0; m_io_oe = '0; m_en = '0; m_flag = '0;
        m_rdata = '0; m_ctrl = '0; m_rvalid = 1'b0;
        qin = {};
        qio = {};
        for (int i = 0; i <= int'(S); i++) begin
            qin.push_front('0);
            qio.push_front('0);
        end

        for (int k = 0; k < cycles; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = 3'($urandom_range(0, 7));
            d  = W'($urandom);
            wr_en = op[0];
            rd_en = op[1];
            addr  = a;
            wdata = d;
            if ($urandom_range(0, 3) == 0) chip_in = W'($urandom);
            if ($urandom_range(0, 3) == 0) io_i = W'($urandom);

            s_in = qin[S-1];
            p_in = qin[S];
            s_io = qio[S-1];
            rise = s_in & ~p_in;
            case (a)
                3'd0: rv = m_out;
                3'd1: rv = m_io_out;
                3'd2: rv = m_io_oe;
                3'd3: rv = s_in;
                3'd4: rv = s_io;
                3'd5: rv = m_en;
                3'd6: rv = m_flag;
                default: rv = W'(m_ctrl);
            endcase
            io_src = m_ctrl[1] ? m_io_out : io_i;
            qin.push_front(chip_in);
            qio.push_front(io_src);
            while (qin.size() > int'(S) + 1) void'(qin.pop_back());
            while (qio.size() > int'(S) + 1) void'(qio.pop_back());

            clr = '0;
            if (op[0] && a == 3'd6) clr = d;
            m_flag = (m_flag & ~clr) | (rise & m_en);
            if (op[0]) begin
                case (a)
                    3'd0: m_out    = d;
                    3'd1: m_io_out = d;
                    3'd2: m_io_oe  = d;
                    3'd5: m_en     = d;
                    3'd7: m_ctrl   = d[1:0];
                    default: ;
                endcase
            end
            m_rvalid = op[1];
            if (op[1]) m_rdata = rv;
            e_chip_out = m_ctrl[0] ? s_in : m_out;
            e_io_oe    = m_ctrl[1] ? '0 : m_io_oe;

            tick();
            chk($sformatf("rnd%0d chip_out", k), chip_out, e_chip_out);
            chk($sformatf("rnd%0d io_o", k), io_o, m_io_out);
            chk($sformatf("rnd%0d io_oe", k), io_oe, e_io_oe);
            chk($sformatf("rnd%0d irq", k), W'(irq), W'(|(m_flag & m_en)));
            chk($sformatf("rnd%0d rvalid", k), W'(rvalid), W'(m_rvalid));
            chk($sformatf("rnd%0d rdata", k), rdata, m_rdata);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        vt[0] = '{a: 3'd0, d: 14'h2A5B, exp: 14'h2A5B};
        vt[1] = '{a: 3'd1, d: 14'h3FFF, exp: 14'h3FFF};
        vt[2] = '{a: 3'd2, d: 14'h1234, exp: 14'h1234};
        vt[3] = '{a: 3'd5, d: 14'h0ABC, exp: 14'h0ABC};
        vt[4] = '{a: 3'd7, d: 14'h3FFC, exp: 14'h0000};
        vt[5] = '{a: 3'd3, d: 14'h1111, exp: 14'h0000};
        vt[6] = '{a: 3'd4, d: 14'h2222, exp: 14'h0000};
        vt[7] = '{a: 3'd6, d: 14'h3FFF, exp: 14'h0000};

        // Reset with random pads, then reset dropping an in-flight rvalid
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        chip_in = W'($urandom);
        io_i    = W'($urandom);
        repeat (3) tick();
        chk("rst io_oe", io_oe, '0);
        chk("rst chip_out", chip_out, '0);
        chk("rst io_o", io_o, '0);
        chk("rst irq", W'(irq), '0);
        chk("rst rvalid", W'(rvalid), '0);
        chk("rst rdata", rdata, '0);
        chip_in = '0;
        io_i    = '0;
        rst_n   = 1'b1;
        repeat (4) tick();
        addr  = 3'd0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pre-drop rvalid", W'(rvalid), W'(1'b1));
        #2 rst_n = 1'b0;
        #1 chk("rvalid dropped", W'(rvalid), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("rvalid after rst", W'(rvalid), '0);

        // OUT write and readback
        wr(3'd0, 14'h2A5B);
        chk("chip_out write", chip_out, 14'h2A5B);
        rd_chk("out rd", 3'd0, 14'h2A5B);
        tick();
        chk("rvalid pulse", W'(rvalid), '0);
        chk("rdata hold", rdata, 14'h2A5B);

        // Register vector table
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr(vt[i].a, vt[i].d);
            rd_chk($sformatf("vec%0d", i), vt[i].a, vt[i].exp);
        end

        // Edge flags, W1C, set-wins, masking
        do_reset();
        wr(3'd5, 14'h0001);
        chip_in = 14'h0001;
        tick();
        tick();
        chk("irq early", W'(irq), '0);
        tick();
        chk("irq set", W'(irq), W'(1'b1));
        rd_chk("flag rd", 3'd6, 14'h0001);
        wr(3'd6, 14'h0001);
        chk("irq w1c", W'(irq), '0);
        chip_in = '0;
        repeat (4) tick();
        chip_in = 14'h0001;
        tick();
        tick();
        wr(3'd6, 14'h0001);
        chk("set wins irq", W'(irq), W'(1'b1));
        rd_chk("set wins flag", 3'd6, 14'h0001);
        wr(3'd5, 14'h0000);
        chk("irq masked", W'(irq), '0);
        rd_chk("flag kept", 3'd6, 14'h0001);

        // MIRROR latency and OUT retention
        do_reset();
        wr(3'd7, 14'h0001);
        chip_in = 14'h1234;
        tick();
        tick();
        chk("mirror early", chip_out, '0);
        tick();
        chk("mirror lat", chip_out, 14'h1234);
        wr(3'd0, 14'h0055);
        chk("mirror hold", chip_out, 14'h1234);
        wr(3'd7, 14'h0000);
        chk("mirror off", chip_out, 14'h0055);

        // LOOPBACK
        do_reset();
        io_i = 14'h3333;
        wr(3'd2, 14'h3FFF);
        chk("oe drive", io_oe, 14'h3FFF);
        wr(3'd1, 14'h0F0F);
        chk("io_o", io_o, 14'h0F0F);
        repeat (S) tick();
        rd_chk("io_in pad", 3'd4, 14'h3333);
        wr(3'd7, 14'h0002);
        chk("lb oe", io_oe, '0);
        repeat (S) tick();
        rd_chk("lb io_in", 3'd4, 14'h0F0F);
        io_i = 14'h1111;
        repeat (S + 1) tick();
        rd_chk("lb indep", 3'd4, 14'h0F0F);
        rd_chk("lb oe reg", 3'd2, 14'h3FFF);

        // Same-cycle write and read
        do_reset();
        addr  = 3'd2;
        wdata = 14'h00FF;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("rw rvalid", W'(rvalid), W'(1'b1));
        chk("rw pre-write", rdata, '0);
        chk("rw io_oe", io_oe, 14'h00FF);
        rd_chk("rw post", 3'd2, 14'h00FF);

        run_random(400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
